// File: rtl/riscv16_pkg.sv
// Shared types and field layout for the RiSC-16 multicycle controller.
// Imported by riscv16_decode and riscv16_ctrl.
package riscv16_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_ADDI = 3'b001,
    OP_NAND = 3'b010,
    OP_LUI  = 3'b011,
    OP_SW   = 3'b100,
    OP_LW   = 3'b101,
    OP_BEQ  = 3'b110,
    OP_JALR = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    ST_RST_WAIT,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_HALT,
    ST_FAULT
  } state_e;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 13;
  localparam int RA_HI  = 12;
  localparam int RA_LO  = 10;
  localparam int RB_HI  = 9;
  localparam int RB_LO  = 7;
  localparam int RC_HI  = 2;
  localparam int RC_LO  = 0;
  localparam int I7_HI  = 6;
  localparam int I10_HI = 9;

  typedef logic [1:0] wsel_t;
  localparam wsel_t WSEL_ALU = 2'd0;
  localparam wsel_t WSEL_MEM = 2'd1;
  localparam wsel_t WSEL_PC1 = 2'd2;

  function automatic logic [15:0] sext7(
    input logic [6:0] i
  );
    return {{9{i[6]}}, i};
  endfunction

endpackage

// File: rtl/riscv16_decode.sv
// Combinational IR decode: register addresses, immediate,
// one-hot ALU control, src2 select and write-back source.
module riscv16_decode
  import riscv16_pkg::*;
(
  input  logic [15:0] ir_i,
  input  state_e      state_i,
  output logic [2:0]  raddr1_o,
  output logic [2:0]  raddr2_o,
  output logic [2:0]  waddr_o,
  output logic [15:0] imm_o,
  output logic        alu_add_o,
  output logic        alu_nand_o,
  output logic        alu_pass1_o,
  output logic        alu_eq_o,
  output logic        src2_imm_o,
  output wsel_t       wsel_o
);

  opcode_e    op;
  logic [2:0] ra;
  logic [2:0] rb;
  logic [2:0] rc;
  logic       active;
  logic       alu_on;

  assign op = opcode_e'(ir_i[OP_HI:OP_LO]);
  assign ra = ir_i[RA_HI:RA_LO];
  assign rb = ir_i[RB_HI:RB_LO];
  assign rc = ir_i[RC_HI:RC_LO];

  assign active = state_i inside
    {ST_DECODE, ST_EXEC, ST_MEM};
  assign alu_on = state_i inside
    {ST_EXEC, ST_MEM};

  always_comb begin
    raddr1_o    = '0;
    raddr2_o    = '0;
    waddr_o     = '0;
    imm_o       = '0;
    alu_add_o   = 1'b0;
    alu_nand_o  = 1'b0;
    alu_pass1_o = 1'b0;
    alu_eq_o    = 1'b0;
    src2_imm_o  = 1'b0;
    wsel_o      = WSEL_ALU;
    if (active) begin
      waddr_o = ra;
      if (op == OP_LUI)
        imm_o = {ir_i[I10_HI:0], 6'b0};
      else
        imm_o = sext7(ir_i[I7_HI:0]);
      unique case (op)
        OP_ADD, OP_NAND: begin
          raddr1_o   = rb;
          raddr2_o   = rc;
          alu_add_o  = alu_on && (op == OP_ADD);
          alu_nand_o = alu_on && (op == OP_NAND);
        end
        OP_ADDI: begin
          raddr1_o   = rb;
          src2_imm_o = alu_on;
          alu_add_o  = alu_on;
        end
        OP_LUI: begin
          raddr1_o   = 3'd0;
          src2_imm_o = alu_on;
          alu_add_o  = alu_on;
        end
        OP_SW, OP_LW: begin
          raddr1_o   = rb;
          raddr2_o   = ra;
          src2_imm_o = alu_on;
          alu_add_o  = alu_on;
          wsel_o     = WSEL_MEM;
        end
        OP_BEQ: begin
          raddr1_o = ra;
          raddr2_o = rb;
          alu_eq_o = alu_on;
        end
        OP_JALR: begin
          raddr1_o    = rb;
          alu_pass1_o = alu_on;
          wsel_o      = WSEL_PC1;
        end
      endcase
    end
  end

endmodule

// File: rtl/riscv16_ctrl.sv
// RiSC-16 multicycle control FSM: PC, IR and memory handshake.
// Optional memory timeout enabled by RISCV16_MEM_TIMEOUT_EN.
module riscv16_ctrl
  import riscv16_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [2:0]  rf_raddr1,
  output logic [2:0]  rf_raddr2,
  input  logic [15:0] rf_rdata2,
  output logic        rf_we,
  output logic [2:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic        alu_add,
  output logic        alu_nand,
  output logic        alu_pass1,
  output logic        alu_eq,
  output logic        alu_src2_imm,
  output logic [15:0] imm_out,
  input  logic [15:0] alu_out,
  input  logic        eq_in,
  output logic [15:0] pc,
  output logic        halt,
  output logic        fault
);

  state_e      state_q;
  state_e      state_d;
  logic [15:0] pc_q;
  logic [15:0] pc_d;
  logic [15:0] ir_q;
  logic [15:0] ir_d;
  logic [15:0] pc_inc;
  logic        we_raw;
  logic        timeout;
  wsel_t       wsel;
  opcode_e     op;

  assign op     = opcode_e'(ir_q[OP_HI:OP_LO]);
  assign pc_inc = pc_q + 16'd1;
  assign pc     = pc_q;

  riscv16_decode u_dec (
    .ir_i        (ir_q),
    .state_i     (state_q),
    .raddr1_o    (rf_raddr1),
    .raddr2_o    (rf_raddr2),
    .waddr_o     (rf_waddr),
    .imm_o       (imm_out),
    .alu_add_o   (alu_add),
    .alu_nand_o  (alu_nand),
    .alu_pass1_o (alu_pass1),
    .alu_eq_o    (alu_eq),
    .src2_imm_o  (alu_src2_imm),
    .wsel_o      (wsel)
  );

`ifdef RISCV16_MEM_TIMEOUT_EN
  localparam int CW =
    ($clog2(MEM_TIMEOUT + 1) > 8) ?
    $clog2(MEM_TIMEOUT + 1) : 8;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          waiting;

  // Count only cycles where a request is pending without ack.
  assign waiting = !mem_ack &&
    (state_q inside {ST_FETCH, ST_MEM});
  assign timeout = waiting &&
    (cnt_q == CW'(MEM_TIMEOUT - 1));
  assign cnt_d = waiting ? cnt_q + 1'b1 : '0;
  assign fault = (state_q == ST_FAULT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^MEM_TIMEOUT;
  assign timeout = 1'b0;
  assign fault   = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    we_raw    = 1'b0;
    halt      = 1'b0;
    unique case (state_q)
      ST_RST_WAIT: state_d = ST_FETCH;
      ST_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_ack) begin
          ir_d    = mem_rdata;
          state_d = ST_DECODE;
        end else if (timeout) begin
          state_d = ST_FAULT;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d    = pc_inc;
        unique case (op)
          OP_ADD, OP_ADDI, OP_NAND, OP_LUI:
            we_raw = 1'b1;
          OP_SW, OP_LW: begin
            pc_d    = pc_q;
            state_d = ST_MEM;
          end
          OP_BEQ:
            if (eq_in)
              pc_d = pc_inc + sext7(ir_q[I7_HI:0]);
          OP_JALR:
            if (ir_q[I7_HI:0] == 7'd0) begin
              we_raw = 1'b1;
              pc_d   = alu_out;
            end else begin
              pc_d    = pc_q;
              state_d = ST_HALT;
            end
        endcase
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        mem_addr = alu_out;
        mem_we   = (op == OP_SW);
        if (op == OP_SW) mem_wdata = rf_rdata2;
        if (mem_ack) begin
          we_raw  = (op == OP_LW);
          pc_d    = pc_inc;
          state_d = ST_FETCH;
        end else if (timeout) begin
          state_d = ST_FAULT;
        end
      end
      ST_HALT:  halt = 1'b1;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_RST_WAIT;
    endcase
  end

  // r0 is hardwired zero, so writes to it are dropped here.
  assign rf_we = we_raw && (rf_waddr != 3'd0);

  always_comb begin
    rf_wdata = '0;
    if (rf_we) begin
      case (wsel)
        WSEL_MEM: rf_wdata = mem_rdata;
        WSEL_PC1: rf_wdata = pc_inc;
        default:  rf_wdata = alu_out;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RST_WAIT;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

endmodule
